// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared drawing types and default screen geometry
//
// Contents:
//   H_RES_DEFAULT / V_RES_DEFAULT  default visible pixels per line / lines per frame
//   X_W / Y_W                      coordinate widths used on every drawing port
//   draw_state_e                   clear-sweep FSM state type
package draw_pkg;

  localparam int H_RES_DEFAULT = 640;
  localparam int V_RES_DEFAULT = 480;
  localparam int X_W           = 10;
  localparam int Y_W           = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } draw_state_e;

endpackage

// File: rtl/clear_sweep.sv
// rtl/clear_sweep.sv - row-major x/y counter for the full-screen clear sweep
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset, returns the counter to (0,0)
//   start    high in every cycle the current (x,y) is being issued; advances the counter
//   x, y     coordinate of the pixel issued this cycle
//   last     high when (x,y) is the bottom-right pixel of the screen
module clear_sweep
  import draw_pkg::*;
#(
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  // Wrapping back to (0,0) after the last pixel leaves the counter ready
  // for the next sweep without a separate restart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - two-requester pixel write arbiter with full-screen clear
//
// Ports:
//   clk, reset_n                 system clock, asynchronous active-low reset
//   clear_req                    request a sweep writing colour 0 to every pixel
//   a_/b_valid, _x, _y, _color   requester pixel write offers
//   a_/b_ready                   combinational accept for each requester
//   wr_en, wr_x, wr_y, wr_color  registered frame-buffer write port
//   busy                         clear sweep in progress
//   cleared                      one-cycle pulse when the sweep has finished
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT,
  parameter int CW    = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear_req,
  input  logic           a_valid,
  input  logic [X_W-1:0] a_x,
  input  logic [Y_W-1:0] a_y,
  input  logic [CW-1:0]  a_color,
  input  logic           b_valid,
  input  logic [X_W-1:0] b_x,
  input  logic [Y_W-1:0] b_y,
  input  logic [CW-1:0]  b_color,
  output logic           a_ready,
  output logic           b_ready,
  output logic           wr_en,
  output logic [X_W-1:0] wr_x,
  output logic [Y_W-1:0] wr_y,
  output logic [CW-1:0]  wr_color,
  output logic           busy,
  output logic           cleared
);

  localparam logic [X_W:0] X_LIM = (X_W + 1)'(H_RES);
  localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(V_RES);

  draw_state_e    state;
  draw_state_e    state_nxt;
  logic           prefer_b;
  logic           in_clear;
  logic           can_grant;
  logic           a_in_range;
  logic           b_in_range;
  logic [X_W-1:0] sw_x;
  logic [Y_W-1:0] sw_y;
  logic           sw_last;

  assign in_clear = (state == ST_CLEAR);

  clear_sweep #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_sweep (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (in_clear),
    .x       (sw_x),
    .y       (sw_y),
    .last    (sw_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clear_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (sw_last)   state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A pending clear blocks requesters in the same cycle so the sweep never
  // races a requester write. prefer_b remembers who was served last.
  assign can_grant = (state == ST_IDLE) && !clear_req;
  assign a_ready   = can_grant && a_valid && (!b_valid || !prefer_b);
  assign b_ready   = can_grant && b_valid && (!a_valid ||  prefer_b);

  // Off-screen pixels are still consumed so the requester never stalls on them.
  assign a_in_range = ({1'b0, a_x} < X_LIM) && ({1'b0, a_y} < Y_LIM);
  assign b_in_range = ({1'b0, b_x} < X_LIM) && ({1'b0, b_y} < Y_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      prefer_b <= 1'b0;
      wr_en    <= 1'b0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_color <= '0;
    end else begin
      state <= state_nxt;
      wr_en <= 1'b0;
      if (in_clear) begin
        wr_en    <= 1'b1;
        wr_x     <= sw_x;
        wr_y     <= sw_y;
        wr_color <= '0;
      end else if (a_ready) begin
        prefer_b <= 1'b1;
        if (a_in_range) begin
          wr_en    <= 1'b1;
          wr_x     <= a_x;
          wr_y     <= a_y;
          wr_color <= a_color;
        end
      end else if (b_ready) begin
        prefer_b <= 1'b0;
        if (b_in_range) begin
          wr_en    <= 1'b1;
          wr_x     <= b_x;
          wr_y     <= b_y;
          wr_color <= b_color;
        end
      end
    end
  end

  assign busy    = (state == ST_CLEAR);
  assign cleared = (state == ST_DONE);

endmodule
